// File: rtl/widen_accum_pkg.sv
// Shared definitions for widen_accum: FSM state encoding and default widths.
// Saturating accumulation is selected by defining WIDEN_ACCUM_SAT_EN.
package widen_accum_pkg;

  localparam int K_DEF  = 8;
  localparam int N_DEF  = 16;
  localparam int CW_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

endpackage

// File: rtl/widen_accum_sat_add.sv
// Signed N-bit adder with overflow detection; clamps on overflow when
// WIDEN_ACCUM_SAT_EN is defined, otherwise wraps modulo 2^N.
module sat_add #(
  parameter int N = 16
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] sum_o,
  output logic         ovf_o
);

  logic [N-1:0] sum_raw;

  assign sum_raw = a_i + b_i;
  // Overflow only possible when both operands share a sign and the result flips it.
  assign ovf_o   = (a_i[N-1] == b_i[N-1]) && (sum_raw[N-1] != a_i[N-1]);

`ifdef WIDEN_ACCUM_SAT_EN
  always_comb begin
    sum_o = sum_raw;
    if (ovf_o) begin
      sum_o = a_i[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    end
  end
`else
  assign sum_o = sum_raw;
`endif

endmodule

// File: rtl/widen_accum.sv
// Frame accumulator: sums i_len signed K-bit samples into an N-bit result.
// Optional saturation via WIDEN_ACCUM_SAT_EN (handled inside sat_add).
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; the producer holds data stable while valid is high and ready is low.
module widen_accum
  import widen_accum_pkg::*;
#(
  parameter int K  = K_DEF,
  parameter int N  = N_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic [K-1:0]  i_data,
  input  logic [CW-1:0] i_len,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [N-1:0]  o_data,
  output logic          o_ovf,
  output logic [1:0]    o_dbg_state
);

  state_e        state_q, state_d;
  logic [N-1:0]  acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] len_q, len_d;
  logic          ovf_q, ovf_d;
  logic          valid_q, ready_q;

  logic [N-1:0]  sample_ext;
  logic [N-1:0]  add_sum;
  logic          add_ovf;
  logic          accept;

  assign sample_ext = {{(N-K){i_data[K-1]}}, i_data};
  assign accept     = i_valid && ready_q;

  sat_add #(.N(N)) u_sat_add (
    .a_i   (acc_q),
    .b_i   (sample_ext),
    .sum_o (add_sum),
    .ovf_o (add_ovf)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          // A zero length is treated as a one-sample frame.
          len_d   = (i_len == '0) ? CW'(1) : i_len;
          acc_d   = sample_ext;
          cnt_d   = CW'(1);
          ovf_d   = 1'b0;
          state_d = (len_d == CW'(1)) ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          acc_d = add_sum;
          ovf_d = ovf_q | add_ovf;
          cnt_d = cnt_q + CW'(1);
          if (cnt_d == len_q) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (i_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
      valid_q <= (state_d == HOLD);
      ready_q <= (state_d != HOLD);
    end
  end

  assign o_valid     = valid_q;
  assign o_ready     = ready_q;
  assign o_data      = acc_q;
  assign o_ovf       = ovf_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_widen_accum.sv
// Bench for widen_accum: N=16 and N=10 instances on shared stimulus, checked
// against a frame-level arithmetic model plus directed literal expectations.
module tb_widen_accum;

`ifdef WIDEN_ACCUM_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid;
  logic [7:0]  i_data;
  logic [7:0]  i_len;
  logic        i_ready;

  logic        o_ready16, o_valid16, o_ovf16;
  logic [15:0] o_data16;
  logic [1:0]  dbg16;
  logic        o_ready10, o_valid10, o_ovf10;
  logic [9:0]  o_data10;
  logic [1:0]  dbg10;

  int n_checks = 0;
  int n_errors = 0;

  // Expected results awaiting handoff: {ovf10, data10, ovf16, data16}
  logic [27:0] exp_q[$];

  bit     m_open;
  int     m_len;
  int     m_cnt;
  longint m_sum[2];
  bit     m_ovf[2];

  always #5 clk = ~clk;

  widen_accum #(.K(8), .N(16), .CW(8)) dut16 (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready16),
    .i_data(i_data), .i_len(i_len), .o_valid(o_valid16), .i_ready(i_ready),
    .o_data(o_data16), .o_ovf(o_ovf16), .o_dbg_state(dbg16)
  );

  widen_accum #(.K(8), .N(10), .CW(8)) dut10 (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready10),
    .i_data(i_data), .i_len(i_len), .o_valid(o_valid10), .i_ready(i_ready),
    .o_data(o_data10), .o_ovf(o_ovf10), .o_dbg_state(dbg10)
  );

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Exact-sum to w-bit result: out of range means overflow; then clamp or wrap.
  function automatic longint fold(input longint v, input int w, output bit o);
    longint lim = longint'(1) <<< (w - 1);
    longint m   = 2 * lim;
    o = (v > lim - 1) || (v < -lim);
    if (!o) return v;
    if (SAT) return (v > 0) ? lim - 1 : -lim;
    return (((v + lim) % m) + m) % m - lim;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      check("rst_valid", o_valid16, 0);
      check("rst_ready", o_ready16, 1);
      check("rst_data", o_data16, 0);
      check("rst_ovf", o_ovf16, 0);
      check("rst_data10", o_data10, 0);
      m_open = 1'b0;
      exp_q.delete();
    end else begin
      bit hold;
      hold = (exp_q.size() != 0);
      check("valid16", o_valid16, longint'(hold));
      check("ready16", o_ready16, longint'(!hold));
      check("valid10", o_valid10, longint'(hold));
      check("ready10", o_ready10, longint'(!hold));
      if (hold) begin
        logic [27:0] e;
        e = exp_q[0];
        check("data16", o_data16, e[15:0]);
        check("ovf16", o_ovf16, e[16]);
        check("data10", o_data10, e[26:17]);
        check("ovf10", o_ovf10, e[27]);
        if (i_ready) void'(exp_q.pop_front());
      end else if (i_valid) begin
        longint x;
        bit o;
        x = longint'($signed(i_data));
        if (!m_open) begin
          m_open = 1'b1;
          m_len  = (i_len == 0) ? 1 : int'(i_len);
          m_cnt  = 0;
          for (int j = 0; j < 2; j++) begin
            m_sum[j] = 0;
            m_ovf[j] = 1'b0;
          end
        end
        m_sum[0] = fold(m_sum[0] + x, 16, o); m_ovf[0] |= o;
        m_sum[1] = fold(m_sum[1] + x, 10, o); m_ovf[1] |= o;
        m_cnt++;
        if (m_cnt == m_len) begin
          exp_q.push_back({m_ovf[1], 10'(m_sum[1]), m_ovf[0], 16'(m_sum[0])});
          m_open = 1'b0;
        end
      end
    end
  end

  task automatic cycle(input bit v, input logic [7:0] d, input logic [7:0] l, input bit r);
    i_valid = v;
    i_data  = d;
    i_len   = l;
    i_ready = r;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] rand_sample();
    if ($urandom_range(1, 0) == 1) return 8'($urandom_range(255, 0));
    if ($urandom_range(1, 0) == 1) return 8'(127 - $urandom_range(20, 0));
    return 8'(128 + $urandom_range(20, 0));
  endfunction

  initial begin
    logic [7:0] smp[4];
    rst = 1'b1;
    i_valid = 1'b0; i_data = '0; i_len = '0; i_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Four-sample frame, no stalls: 10 - 3 + 127 - 128 = 6
    smp[0] = 8'd10; smp[1] = 8'hFD; smp[2] = 8'd127; smp[3] = 8'h80;
    for (int i = 0; i < 4; i++) begin
      check("frame4_not_valid_yet", o_valid16, 0);
      cycle(1'b1, smp[i], 8'd4, 1'b0);
    end
    check("frame4_valid", o_valid16, 1);
    check("frame4_data", o_data16, 16'd6);
    check("frame4_ovf", o_ovf16, 0);

    // Downstream stall with pending input: result held, nothing accepted
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'd55, 8'd3, 1'b0);
    check("stall_valid", o_valid16, 1);
    check("stall_ready", o_ready16, 0);
    check("stall_data", o_data16, 16'd6);
    check("stall_ovf", o_ovf16, 0);
    cycle(1'b0, 8'd0, 8'd0, 1'b1);
    check("bubble_valid", o_valid16, 0);
    check("bubble_ready", o_ready16, 1);

    // Zero length behaves as a single-sample frame
    cycle(1'b1, 8'hFB, 8'd0, 1'b0);
    check("len0_valid", o_valid16, 1);
    check("len0_data", o_data16, 16'hFFFB);
    check("len0_ovf", o_ovf16, 0);
    cycle(1'b0, 8'd0, 8'd0, 1'b1);

    // Eight times 127 overflows a 10-bit accumulator
    for (int i = 0; i < 8; i++) cycle(1'b1, 8'd127, 8'd8, 1'b0);
    check("ovf10_valid", o_valid10, 1);
    check("ovf10_data", o_data10, SAT ? 10'd511 : 10'h3F8);
    check("ovf10_flag", o_ovf10, 1);
    check("ovf16_data", o_data16, 16'd1016);
    check("ovf16_flag", o_ovf16, 0);
    cycle(1'b0, 8'd0, 8'd0, 1'b1);

    // Reset mid-frame discards the partial sum
    cycle(1'b1, 8'd9, 8'd4, 1'b0);
    cycle(1'b1, 8'd9, 8'd4, 1'b0);
    i_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_valid", o_valid16, 0);
    check("midrst_data", o_data16, 0);
    check("midrst_ready", o_ready16, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'd1, 8'd4, 1'b0);
    check("fresh_valid", o_valid16, 1);
    check("fresh_data", o_data16, 16'd4);
    cycle(1'b0, 8'd0, 8'd0, 1'b1);

    // Randomized traffic with random stalls, lengths and extreme samples
    for (int i = 0; i < 2000; i++) begin
      cycle($urandom_range(9, 0) < 7, rand_sample(), 8'($urandom_range(9, 0)),
            $urandom_range(9, 0) < 6);
    end
    for (int i = 0; i < 20; i++) cycle(1'b0, 8'd0, 8'd0, 1'b1);
    check("drain_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
